strobe_pwm: RTL
===============

# strobe_pwm

Tick-driven PWM generator that consumes the single-cycle `strobe` of `counter_with_strobe`, wired to `tick`, as its time base. It sits directly downstream of that prescaler. It counts ticks into a programmable period and drives a duty-cycled output. Configuration uses a valid/ready handshake and is double-buffered so that changes apply only at period boundaries.

## Interface
- `WIDTH`, 8: width of the tick position counter, period and duty.
- `DEAD_WIDTH`, 4: width of the dead-time value. Used only when `STROBE_PWM_DEADTIME_EN` is defined.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `tick`  in  1  time-base pulse, typically the prescaler `strobe`. Back-to-back ticks are legal.
- `run`  in  1  level request to generate PWM.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted.
- `cfg_period`  in  WIDTH  ticks per period (P).
- `cfg_duty`  in  WIDTH  high ticks per period (D).
- `cfg_dead`  in  DEAD_WIDTH  dead-time in ticks. Present only with the macro.
- `pwm_out`  out  1  PWM output, registered.
- `pwm_out_n`  out  1  complementary output, registered. Present only with the macro.
- `period_done`  out  1  one-cycle pulse at each period wrap.

## Operation
- **Registers**
  - Active set: P_a, D_a (and dead_a).
  - Shadow set: P_s, D_s (and dead_s), plus a `pending` flag.
  - Position counter `cnt`, `WIDTH` bits.
- **Handshake**
  - `cfg_ready = !pending`.
  - A transfer occurs on an edge where `cfg_valid && cfg_ready`.
  - In IDLE, a transfer loads the active set directly; `pending` stays 0.
  - In RUN or STOPPING, a transfer loads the shadow set and sets `pending`.
- **States**
  - IDLE: `cnt`=0, outputs low.
    - `run && P_a != 0` → RUN. On that edge: `cnt` ← 0, raw ← (D_a > 0).
  - RUN: on each `tick`:
    - If `cnt == P_a-1`, wrap: `cnt` ← 0 and `period_done` ← 1. If `pending`, copy shadow to active and clear `pending`.
    - Otherwise `cnt` ← `cnt`+1.
    - `!run` → STOPPING, with no output change.
  - STOPPING: counts exactly as RUN.
    - At the next wrap → IDLE, outputs ← 0, `period_done` still pulses.
    - `run` reasserted before the wrap → RUN with no gap.
- **Raw output**: raw ← (cnt_next < D_a_next), evaluated with post-update values.
  - D ≥ P gives a constant high.
  - D = 0 gives a constant low.
- **P = 0 handling**
  - P_a = 0 blocks leaving IDLE.
  - A shadow P_s = 0 applied at a wrap forces → IDLE on that edge.
- **Arithmetic**: unsigned compares; `P_a-1` is computed only when P_a ≠ 0, so no wrap-around.
- **Simultaneous events**
  - Transfer on the same edge as a wrap: the new values go to the shadow and apply at the following wrap, not this one.
  - `tick` on the edge where `run` falls: processed as in RUN.
- **Reset mid-operation**: → IDLE, all registers cleared, `pending`=0, outputs 0 on the next edge.

## Timing
- Reset values: `pwm_out`=0, `pwm_out_n`=0, `period_done`=0, `cfg_ready`=1, `cnt`=0, active and shadow sets = 0.
- `pwm_out` and `period_done` update on the same edge that consumes `tick`, i.e. one clock after `tick` is sampled high.
- RUN period length is exactly P_a ticks.
- `period_done` is high for exactly one clock per wrap.
- `cfg_ready` falls the edge after a transfer in RUN and rises the edge after the applying wrap.
- IDLE → RUN takes one edge after `run` is sampled.

## Configuration
- Macro: `STROBE_PWM_DEADTIME_EN`.
- **Defined**
  - `cfg_dead` and `pwm_out_n` exist.
  - Outputs are derived from raw with dead-time insertion, counted in ticks:
    - On each raw edge, both outputs go low.
    - After dead_a ticks, the output matching the new raw level rises.
  - If raw toggles again before dead_a ticks elapse, the dead counter restarts and both outputs stay low.
  - dead_a = 0 gives `pwm_out`=raw and `pwm_out_n`=!raw in RUN.
  - Both outputs are 0 in IDLE and on reset.
- **Undefined**: the ports are absent and `pwm_out` = raw.

## Test plan
- **Basic PWM**
  - Stimulus: reset; config P=4, D=1 in IDLE; `run`=1; tick every 3rd clock.
  - Response: `pwm_out` high 1 tick, low 3 ticks; `period_done` every 12 clocks, one clock wide.
- **Double buffering**
  - Stimulus: running P=4, D=2; transfer P=5, D=3 mid-period.
  - Response: current period finishes as 4/2; next period is 5/3; `cfg_ready` is low until that wrap.
- **Transfer on a wrap edge**
  - Stimulus: transfer on the same edge as a wrap.
  - Response: the new values take effect one full period later.
- **Duty edge cases**
  - D=0 → constant low.
  - D=P=3 → constant high, with `period_done` still pulsing every 3 ticks.
  - P=0 with `run`=1 → stays IDLE, outputs 0.
- **Stop and reset**
  - `run` dropped at `cnt`=1 of P=4 → 2 more ticks, wrap pulse, then IDLE with outputs 0.
  - `rst` mid-period → all outputs 0 and `cfg_ready`=1 next clock.
- **Dead time** (macro defined)
  - Stimulus: P=8, D=4, dead=2.
  - Response: `pwm_out` high 2 ticks, `pwm_out_n` high 2 ticks, with 2-tick both-low gaps between them.
  - Stimulus: dead=5.
  - Response: both outputs stay low.

Source files
------------

// File: rtl/strobe_pwm.sv
// strobe_pwm: tick-driven PWM generator with double-buffered configuration.
//
// Counts `tick` pulses (typically the single-cycle strobe of an upstream
// prescaler) into a programmable period and drives a duty-cycled output.
// New period/duty values written while running are parked in a shadow set
// and only take effect at the next period wrap.
//
// Optional feature macro: STROBE_PWM_DEADTIME_EN
//   When defined, adds cfg_dead / pwm_out_n and inserts dead time (counted
//   in ticks) between the complementary outputs.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   tick            time-base pulse, back-to-back pulses allowed
//   run             level request to generate PWM
//   cfg_valid       configuration offered
//   cfg_ready       configuration can be accepted (= no shadow pending)
//   cfg_period      ticks per period
//   cfg_duty        high ticks per period
//   cfg_dead        dead time in ticks (macro only)
//   pwm_out         PWM output, registered
//   pwm_out_n       complementary output, registered (macro only)
//   period_done     one-cycle pulse at each period wrap
//   state_dbg       current FSM state (0 idle, 1 run, 2 stopping)
//
// Configuration handshake: a transfer happens on a rising clk edge where
// cfg_valid && cfg_ready are both high; cfg_ready does not depend on
// cfg_valid, and the offered values must be held stable while cfg_valid is
// high without a transfer.
module strobe_pwm #(
  parameter int WIDTH      = 8,
  parameter int DEAD_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  run,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_period,
  input  logic [WIDTH-1:0]      cfg_duty,
`ifdef STROBE_PWM_DEADTIME_EN
  input  logic [DEAD_WIDTH-1:0] cfg_dead,
  output logic                  pwm_out_n,
`endif
  output logic                  pwm_out,
  output logic                  period_done,
  output logic [1:0]            state_dbg
);

  if (WIDTH < 1 || DEAD_WIDTH < 1) begin : g_param_check
    $error("strobe_pwm: WIDTH and DEAD_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = 1;

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] cnt_q, cnt_nx;
  logic [WIDTH-1:0] p_a_q, p_a_nx, d_a_q, d_a_nx;
  logic [WIDTH-1:0] p_s_q, p_s_nx, d_s_q, d_s_nx;
  logic             pending_q, pending_nx;
  logic             raw_q, raw_nx;
  logic             done_q, done_nx;

  logic running, xfer, at_last, wrap, apply_shadow;

  assign cfg_ready    = !pending_q;
  assign xfer         = cfg_valid && cfg_ready;
  assign running      = (state_q != S_IDLE);
  // Guarding on p_a_q != 0 keeps p_a_q-1 from wrapping around.
  assign at_last      = (p_a_q != '0) && (cnt_q == p_a_q - ONE);
  assign wrap         = running && tick && at_last;
  assign apply_shadow = wrap && pending_q;

  assign period_done  = done_q;
  assign state_dbg    = state_q;

  always_comb begin
    state_nx   = state_q;
    cnt_nx     = cnt_q;
    p_a_nx     = p_a_q;
    d_a_nx     = d_a_q;
    p_s_nx     = p_s_q;
    d_s_nx     = d_s_q;
    pending_nx = pending_q;
    raw_nx     = raw_q;
    done_nx    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_nx = '0;
        raw_nx = 1'b0;
        // In idle there is nothing to protect, so a transfer goes live at once.
        if (xfer) begin
          p_a_nx = cfg_period;
          d_a_nx = cfg_duty;
        end
        if (run && (p_a_nx != '0)) begin
          state_nx = S_RUN;
          raw_nx   = (d_a_nx != '0);
        end
      end
      default: begin
        if (xfer) begin
          p_s_nx     = cfg_period;
          d_s_nx     = cfg_duty;
          pending_nx = 1'b1;
        end
        if (tick) begin
          if (at_last) begin
            cnt_nx  = '0;
            done_nx = 1'b1;
            // pending_q (not pending_nx): a transfer on this same edge waits
            // for the following wrap.
            if (pending_q) begin
              p_a_nx     = p_s_q;
              d_a_nx     = d_s_q;
              pending_nx = 1'b0;
            end
          end else begin
            cnt_nx = cnt_q + ONE;
          end
          raw_nx = (cnt_nx < d_a_nx);
        end
        // A zero period arriving from the shadow, or a wrap while stopping,
        // returns to idle; period_done still pulses on that edge.
        if (wrap && ((p_a_nx == '0) || ((state_q == S_STOP) && !run))) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          raw_nx   = 1'b0;
        end else if ((state_q == S_RUN) && !run) begin
          state_nx = S_STOP;
        end else if ((state_q == S_STOP) && run) begin
          state_nx = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_a_q     <= '0;
      d_a_q     <= '0;
      p_s_q     <= '0;
      d_s_q     <= '0;
      pending_q <= 1'b0;
      raw_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      p_a_q     <= p_a_nx;
      d_a_q     <= d_a_nx;
      p_s_q     <= p_s_nx;
      d_s_q     <= d_s_nx;
      pending_q <= pending_nx;
      raw_q     <= raw_nx;
      done_q    <= done_nx;
    end
  end

`ifdef STROBE_PWM_DEADTIME_EN
  localparam logic [DEAD_WIDTH-1:0] D_ONE = 1;

  logic [DEAD_WIDTH-1:0] dead_a_q, dead_a_nx, dead_s_q, dead_s_nx;
  logic [DEAD_WIDTH-1:0] dcnt_q, dcnt_nx;
  logic                  out_q, out_nx, out_n_q, out_n_nx;
  logic                  start_run;

  // Entering RUN counts as a raw edge so the low-side output also gets its
  // dead time when the first raw level is 0.
  assign start_run = (state_q == S_IDLE) && (state_nx == S_RUN);

  always_comb begin
    dead_a_nx = dead_a_q;
    dead_s_nx = dead_s_q;
    dcnt_nx   = dcnt_q;
    out_nx    = out_q;
    out_n_nx  = out_n_q;
    if (!running && xfer) dead_a_nx = cfg_dead;
    if (running && xfer)  dead_s_nx = cfg_dead;
    if (apply_shadow)     dead_a_nx = dead_s_q;

    if (state_nx == S_IDLE) begin
      out_nx   = 1'b0;
      out_n_nx = 1'b0;
      dcnt_nx  = '0;
    end else if (start_run || (raw_nx != raw_q)) begin
      if (dead_a_nx == '0) begin
        out_nx   = raw_nx;
        out_n_nx = !raw_nx;
        dcnt_nx  = '0;
      end else begin
        out_nx   = 1'b0;
        out_n_nx = 1'b0;
        dcnt_nx  = dead_a_nx;
      end
    end else if (tick && (dcnt_q != '0)) begin
      dcnt_nx = dcnt_q - D_ONE;
      if (dcnt_q == D_ONE) begin
        out_nx   = raw_nx;
        out_n_nx = !raw_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dead_a_q <= '0;
      dead_s_q <= '0;
      dcnt_q   <= '0;
      out_q    <= 1'b0;
      out_n_q  <= 1'b0;
    end else begin
      dead_a_q <= dead_a_nx;
      dead_s_q <= dead_s_nx;
      dcnt_q   <= dcnt_nx;
      out_q    <= out_nx;
      out_n_q  <= out_n_nx;
    end
  end

  assign pwm_out   = out_q;
  assign pwm_out_n = out_n_q;
`else
  assign pwm_out = raw_q;
`endif

endmodule
